// File: rtl/lock_auto_operator.sv
// Automatic lock-keeper: accepts gondola requests, levels the chamber and
// issues the door-open pulses a human operator would, on the lock tick clock.
module lock_auto_operator #(
  parameter int ARR_DELAY     = 5,
  parameter int DEPT_DELAY    = 5,
  parameter int LEVEL_TIMEOUT = 64,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             outer_req,
  input  logic             inner_req,
  input  logic             outer_door_openable,
  input  logic             inner_door_openable,
  output logic             inc_water_level,
  output logic             dec_water_level,
  output logic             outer_door_sw,
  output logic             inner_door_sw,
  output logic             busy,
  output logic             to_inner,
  output logic             fault,
  output logic [2:0]       state_code
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEVEL_ARR = 3'd1,
    WAIT_ARR  = 3'd2,
    OPEN_ARR  = 3'd3,
    LEVEL_DEP = 3'd4,
    OPEN_DEP  = 3'd5,
    DEPART    = 3'd6,
    FAULT     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ARR_MAX  = CNT_W'(ARR_DELAY);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_DELAY - 1);
  localparam logic [CNT_W-1:0] DEP_LAST = CNT_W'(DEPT_DELAY - 1);
  localparam logic [CNT_W-1:0] LVL_MAX  = CNT_W'(LEVEL_TIMEOUT);

  state_t           state, state_n;
  logic [CNT_W-1:0] arr_cnt, arr_cnt_n;
  logic [CNT_W-1:0] lvl_cnt, lvl_cnt_n;
  logic [CNT_W-1:0] dep_cnt, dep_cnt_n;
  logic [CNT_W-1:0] lvl_inc;
  logic             to_inner_n;
  logic             inc_n, dec_n, outer_sw_n, inner_sw_n;
  logic             arr_flag, dep_flag;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                              input logic [CNT_W-1:0] lim);
    return (v < lim) ? v + CNT_W'(1) : v;
  endfunction

  assign arr_flag   = to_inner ? outer_door_openable : inner_door_openable;
  assign dep_flag   = to_inner ? inner_door_openable : outer_door_openable;
  assign lvl_inc    = sat_inc(lvl_cnt, LVL_MAX);
  assign state_code = state;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    to_inner_n = to_inner;
    arr_cnt_n  = (state == IDLE) ? arr_cnt : sat_inc(arr_cnt, ARR_MAX);
    lvl_cnt_n  = lvl_cnt;
    dep_cnt_n  = dep_cnt;
    inc_n      = 1'b0;
    dec_n      = 1'b0;
    outer_sw_n = 1'b0;
    inner_sw_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (outer_req || inner_req) begin
          to_inner_n = outer_req;
          state_n    = LEVEL_ARR;
          arr_cnt_n  = '0;
          lvl_cnt_n  = '0;
        end
      end
      LEVEL_ARR: begin
        if (arr_flag) begin
          state_n = WAIT_ARR;
        end else begin
          lvl_cnt_n = lvl_inc;
          if (lvl_inc == LVL_MAX) state_n = FAULT;
          else if (to_inner)      dec_n   = 1'b1;
          else                    inc_n   = 1'b1;
        end
      end
      WAIT_ARR: begin
        if (!arr_flag) begin
          state_n   = LEVEL_ARR;
          lvl_cnt_n = '0;
        end else if (arr_cnt >= ARR_LAST) begin
          // The count advancing on this edge completes the arrival delay, so
          // the door pulse lands ARR_DELAY edges after acceptance.
          state_n    = OPEN_ARR;
          outer_sw_n = to_inner;
          inner_sw_n = !to_inner;
        end
      end
      OPEN_ARR: begin
        state_n   = arr_flag ? LEVEL_DEP : LEVEL_ARR;
        lvl_cnt_n = '0;
      end
      LEVEL_DEP: begin
        if (dep_flag) begin
          state_n    = OPEN_DEP;
          inner_sw_n = to_inner;
          outer_sw_n = !to_inner;
        end else begin
          lvl_cnt_n = lvl_inc;
          if (lvl_inc == LVL_MAX) state_n = FAULT;
          else if (to_inner)      inc_n   = 1'b1;
          else                    dec_n   = 1'b1;
        end
      end
      OPEN_DEP: begin
        if (dep_flag) begin
          state_n   = DEPART;
          dep_cnt_n = '0;
        end else begin
          state_n   = LEVEL_DEP;
          lvl_cnt_n = '0;
        end
      end
      DEPART: begin
        dep_cnt_n = sat_inc(dep_cnt, DEP_LAST);
        if (dep_cnt == DEP_LAST) state_n = IDLE;
      end
      FAULT: ;
      default: state_n = FAULT;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      arr_cnt         <= '0;
      lvl_cnt         <= '0;
      dep_cnt         <= '0;
      to_inner        <= 1'b0;
      inc_water_level <= 1'b0;
      dec_water_level <= 1'b0;
      outer_door_sw   <= 1'b0;
      inner_door_sw   <= 1'b0;
      busy            <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_n;
      arr_cnt         <= arr_cnt_n;
      lvl_cnt         <= lvl_cnt_n;
      dep_cnt         <= dep_cnt_n;
      to_inner        <= to_inner_n;
      inc_water_level <= inc_n;
      dec_water_level <= dec_n;
      outer_door_sw   <= outer_sw_n;
      inner_door_sw   <= inner_sw_n;
      busy            <= (state_n != IDLE) && (state_n != FAULT);
      fault           <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_lock_auto_operator.sv
// Directed bench for lock_auto_operator with a simple water-level model:
// outer level is 0 (openable at <=1), inner level is 5 and above.
module tb_lock_auto_operator;

  logic       clk = 1'b0;
  logic       reset;
  logic       outer_req, inner_req;
  logic       outer_door_openable, inner_door_openable;
  logic       inc_water_level, dec_water_level;
  logic       outer_door_sw, inner_door_sw;
  logic       busy, to_inner, fault;
  logic [2:0] state_code;

  int tests  = 0;
  int failed = 0;

  int   level = 0;
  logic lvl_load = 1'b0;
  int   lvl_load_val = 0;
  logic stuck_inner = 1'b0;

  always #5 clk = ~clk;

  lock_auto_operator dut (
    .clk                 (clk),
    .reset               (reset),
    .outer_req           (outer_req),
    .inner_req           (inner_req),
    .outer_door_openable (outer_door_openable),
    .inner_door_openable (inner_door_openable),
    .inc_water_level     (inc_water_level),
    .dec_water_level     (dec_water_level),
    .outer_door_sw       (outer_door_sw),
    .inner_door_sw       (inner_door_sw),
    .busy                (busy),
    .to_inner            (to_inner),
    .fault               (fault),
    .state_code          (state_code)
  );

  always @(posedge clk) begin
    if (lvl_load) level <= lvl_load_val;
    else          level <= level + (inc_water_level ? 1 : 0) - (dec_water_level ? 1 : 0);
  end

  assign outer_door_openable = (level <= 1);
  assign inner_door_openable = !stuck_inner && (level >= 5);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic set_level(input int v);
    lvl_load_val = v;
    lvl_load     = 1'b1;
    tick();
    lvl_load     = 1'b0;
  endtask

  // Watches edges 1..max_edges after acceptance; stops once busy falls.
  task automatic observe(input int max_edges, output int osw_at, output int isw_at,
                         output int inc_n, output int dec_n, output int busy_fall,
                         output int inv_bad);
    logic po, pi;
    osw_at = -1; isw_at = -1; inc_n = 0; dec_n = 0; busy_fall = -1; inv_bad = 0;
    for (int e = 1; e <= max_edges && busy_fall < 0; e++) begin
      po = outer_door_openable;
      pi = inner_door_openable;
      tick();
      if (inc_water_level) inc_n++;
      if (dec_water_level) dec_n++;
      if (inc_water_level && dec_water_level) inv_bad++;
      if (outer_door_sw && inner_door_sw) inv_bad++;
      if ((outer_door_sw || inner_door_sw) && !(state_code == 3'd3 || state_code == 3'd5)) inv_bad++;
      if (outer_door_sw) begin
        if (osw_at < 0) osw_at = e; else inv_bad++;
        if (!po) inv_bad++;
      end
      if (inner_door_sw) begin
        if (isw_at < 0) isw_at = e; else inv_bad++;
        if (!pi) inv_bad++;
      end
      if (!busy) busy_fall = e;
    end
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    int nz = 0;
    reset = 1'b1; outer_req = 1'b1; inner_req = 1'b0;
    repeat (3) begin
      tick();
      outs = {inc_water_level, dec_water_level, outer_door_sw, inner_door_sw,
              busy, to_inner, fault, state_code};
      if (outs !== 10'd0) nz++;
    end
    tests++; if (nz !== 0) begin failed++; $display("FAIL reset_outputs: nonzero cycles %0d, want 0", nz); end
    reset = 1'b0;
    tests++; if (state_code !== 3'd0) begin failed++; $display("FAIL release_idle: state %0d, want 0", state_code); end
    tick();
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL accept_busy: got %b, want 1", busy); end
    tests++; if (to_inner !== 1'b1) begin failed++; $display("FAIL accept_dir: got %b, want 1", to_inner); end
    tests++; if (state_code !== 3'd1) begin failed++; $display("FAIL accept_state: got %0d, want 1", state_code); end
    outer_req = 1'b0;
    do_reset();
  endtask

  task automatic test_outer_to_inner();
    int o, i, ic, dc, bf, bad;
    set_level(0);
    outer_req = 1'b1; tick(); outer_req = 1'b0;
    observe(60, o, i, ic, dc, bf, bad);
    tests++; if (o !== 5)   begin failed++; $display("FAIL o2i_outer_sw: edge %0d, want 5", o); end
    tests++; if (i !== 13)  begin failed++; $display("FAIL o2i_inner_sw: edge %0d, want 13", i); end
    tests++; if (ic !== 6)  begin failed++; $display("FAIL o2i_inc_cycles: got %0d, want 6", ic); end
    tests++; if (dc !== 0)  begin failed++; $display("FAIL o2i_dec_cycles: got %0d, want 0", dc); end
    tests++; if (bf !== 19) begin failed++; $display("FAIL o2i_busy_fall: edge %0d, want 19", bf); end
    tests++; if (bad !== 0) begin failed++; $display("FAIL o2i_invariants: violations %0d, want 0", bad); end
  endtask

  task automatic test_inner_to_outer();
    int o, i, ic, dc, bf, bad;
    set_level(0);
    inner_req = 1'b1; tick(); inner_req = 1'b0;
    tests++; if (to_inner !== 1'b0) begin failed++; $display("FAIL i2o_dir: got %b, want 0", to_inner); end
    observe(60, o, i, ic, dc, bf, bad);
    tests++; if (i !== 8)   begin failed++; $display("FAIL i2o_inner_sw: edge %0d, want 8", i); end
    tests++; if (o !== 16)  begin failed++; $display("FAIL i2o_outer_sw: edge %0d, want 16", o); end
    tests++; if (ic !== 6)  begin failed++; $display("FAIL i2o_inc_cycles: got %0d, want 6", ic); end
    tests++; if (dc !== 6)  begin failed++; $display("FAIL i2o_dec_cycles: got %0d, want 6", dc); end
    tests++; if (bf !== 22) begin failed++; $display("FAIL i2o_busy_fall: edge %0d, want 22", bf); end
    tests++; if (bad !== 0) begin failed++; $display("FAIL i2o_invariants: violations %0d, want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int o, i, ic, dc, bf, bad;
    set_level(0);
    outer_req = 1'b1; inner_req = 1'b1; tick(); outer_req = 1'b0;
    tests++; if (to_inner !== 1'b1)    begin failed++; $display("FAIL both_dir: got %b, want 1", to_inner); end
    tests++; if (state_code !== 3'd1)  begin failed++; $display("FAIL both_state: got %0d, want 1", state_code); end
    observe(60, o, i, ic, dc, bf, bad);
    tests++; if (i !== 13)  begin failed++; $display("FAIL held_inner_sw: edge %0d, want 13", i); end
    tests++; if (bf !== 19) begin failed++; $display("FAIL held_busy_fall: edge %0d, want 19", bf); end
    tick();
    tests++; if (busy !== 1'b1)       begin failed++; $display("FAIL requeue_busy: got %b, want 1", busy); end
    tests++; if (to_inner !== 1'b0)   begin failed++; $display("FAIL requeue_dir: got %b, want 0", to_inner); end
    tests++; if (state_code !== 3'd1) begin failed++; $display("FAIL requeue_state: got %0d, want 1", state_code); end
    inner_req = 1'b0;
    do_reset();
  endtask

  task automatic test_level_timeout();
    int o, i, ic, dc, bf, bad;
    set_level(0);
    stuck_inner = 1'b1;
    outer_req = 1'b1; tick(); outer_req = 1'b0;
    observe(100, o, i, ic, dc, bf, bad);
    tests++; if (bf !== 70)  begin failed++; $display("FAIL timeout_edge: edge %0d, want 70", bf); end
    tests++; if (ic !== 63)  begin failed++; $display("FAIL timeout_inc_cycles: got %0d, want 63", ic); end
    tests++; if (i !== -1)   begin failed++; $display("FAIL timeout_inner_sw: edge %0d, want none", i); end
    repeat (3) tick();
    tests++; if (state_code !== 3'd7) begin failed++; $display("FAIL fault_state: got %0d, want 7", state_code); end
    tests++; if (fault !== 1'b1)      begin failed++; $display("FAIL fault_flag: got %b, want 1", fault); end
    tests++; if ({inc_water_level, dec_water_level, outer_door_sw, inner_door_sw, busy} !== 5'd0)
      begin failed++; $display("FAIL fault_outputs: got %b, want 00000",
                               {inc_water_level, dec_water_level, outer_door_sw, inner_door_sw, busy}); end
    stuck_inner = 1'b0;
    do_reset();
    tests++; if (fault !== 1'b0)      begin failed++; $display("FAIL fault_clear: got %b, want 0", fault); end
    tests++; if (state_code !== 3'd0) begin failed++; $display("FAIL fault_clear_state: got %0d, want 0", state_code); end
  endtask

  task automatic test_reset_mid_wait();
    int sw = 0;
    set_level(0);
    outer_req = 1'b1; tick(); outer_req = 1'b0;
    repeat (3) tick();
    tests++; if (state_code !== 3'd2) begin failed++; $display("FAIL mid_wait_state: got %0d, want 2", state_code); end
    reset = 1'b1;
    tick();
    tests++; if ({inc_water_level, dec_water_level, outer_door_sw, inner_door_sw,
                 busy, to_inner, fault, state_code} !== 10'd0)
      begin failed++; $display("FAIL abort_outputs: state %0d busy %b, want all 0", state_code, busy); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (outer_door_sw || inner_door_sw) sw++;
    end
    tests++; if (sw !== 0)            begin failed++; $display("FAIL abort_no_pulse: pulses %0d, want 0", sw); end
    tests++; if (state_code !== 3'd0) begin failed++; $display("FAIL abort_idle: got %0d, want 0", state_code); end
  endtask

  initial begin
    reset = 1'b1; outer_req = 1'b0; inner_req = 1'b0;
    test_reset();
    test_outer_to_inner();
    test_inner_to_outer();
    test_back_to_back();
    test_level_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lock_auto_operator.md
Name: lock_auto_operator

Overview:
- Automatic lock-keeper: the initiator end of the lock's operator interface.
- Accepts gondola arrival requests and watches the water system's door-openable flags.
- Drives the same control pulses a human operator would: water inc/dec, outer/inner door-open switches. These feed the gondola/door controller and the water system in place of the debounced switches.
- Runs on the same slow tick clock as the lock system.

Parameters:
ARR_DELAY, 5, minimum cycles from request acceptance to the arrival-door pulse
DEPT_DELAY, 5, cycles held in DEPART after the departure-door pulse before returning to IDLE
LEVEL_TIMEOUT, 64, maximum cycles allowed in one leveling state before FAULT
CNT_W, 8, width of the internal counters; must hold max(ARR_DELAY, DEPT_DELAY, LEVEL_TIMEOUT)

Ports:
clk  in  1  tick clock
reset  in  1  synchronous, active-high
outer_req  in  1  gondola waiting at the outer side, level-sensitive
inner_req  in  1  gondola waiting at the inner side, level-sensitive
outer_door_openable  in  1  water level is within tolerance of the outer level
inner_door_openable  in  1  water level is within tolerance of the inner level
inc_water_level  out  1  registered; raise water one step per cycle while high
dec_water_level  out  1  registered; lower water one step per cycle while high
outer_door_sw  out  1  registered one-cycle outer door-open pulse
inner_door_sw  out  1  registered one-cycle inner door-open pulse
busy  out  1  high in every state except IDLE and FAULT
to_inner  out  1  direction of the current traversal, 1 = outer->inner; valid while busy
fault  out  1  sticky leveling-timeout flag
state_code  out  3  current FSM state encoding, for HEX display

Behaviour:
- Reset, sampled at posedge:
  - All outputs 0; state IDLE (code 0); counters 0.
  - Reset mid-traversal aborts immediately. No further pulses are issued.
- All outputs are registered. Each output reflects the state and inputs sampled at the previous edge, so there is a 1-cycle latency from input to output.
- States and codes: IDLE=0, LEVEL_ARR=1, WAIT_ARR=2, OPEN_ARR=3, LEVEL_DEP=4, OPEN_DEP=5, DEPART=6, FAULT=7.
- IDLE:
  - If outer_req, latch to_inner=1.
  - Else if inner_req, latch to_inner=0.
  - Outer wins when both are high.
  - On acceptance: go to LEVEL_ARR, clear arr_cnt and lvl_cnt, busy=1.
  - Requests are ignored in every other state; they are not queued.
- Arrival-side flag = outer_door_openable if to_inner, else inner_door_openable. Departure-side flag is the opposite one.
- arr_cnt increments every cycle from acceptance and saturates at ARR_DELAY.
- LEVEL_ARR:
  - If the arrival flag is 1, go to WAIT_ARR with inc=dec=0.
  - Otherwise drive dec (if to_inner) or inc (if !to_inner) high and increment lvl_cnt.
  - When lvl_cnt reaches LEVEL_TIMEOUT, go to FAULT.
- WAIT_ARR:
  - Hold until arr_cnt >= ARR_DELAY, then go to OPEN_ARR.
  - If the arrival flag drops meanwhile, return to LEVEL_ARR with lvl_cnt cleared.
- OPEN_ARR:
  - Arrival-side door_sw is high for exactly this one cycle.
  - Next state is LEVEL_DEP, with lvl_cnt cleared.
- LEVEL_DEP:
  - Mirror of LEVEL_ARR against the departure flag, driving the opposite water command.
  - Same timeout rule.
  - On the flag being 1, go to OPEN_DEP.
- OPEN_DEP:
  - Departure-side door_sw is high for one cycle.
  - Clear dep_cnt; go to DEPART.
- DEPART:
  - dep_cnt increments each cycle.
  - At dep_cnt == DEPT_DELAY-1, go to IDLE. DEPART therefore lasts exactly DEPT_DELAY cycles.
  - busy falls on entering IDLE.
- FAULT:
  - fault=1, busy=0, all pulses 0.
  - Left only by reset.
- Invariants:
  - inc and dec are never both high.
  - At most one door_sw is high, and only in OPEN_ARR or OPEN_DEP.
  - A door_sw is never issued while its own openable flag is 0. If the flag is 0 at an OPEN state, suppress the pulse and return to the matching LEVEL state.
- Counters saturate and never wrap.

Test Plan:
- Reset with outer_req=1 held: all outputs 0 during reset. First cycle after release is IDLE; next cycle busy=1, to_inner=1, state_code=1.
- Outer->inner traversal, bench water model starting at outer level (outer_openable=1): no water pulses in LEVEL_ARR. outer_door_sw pulses at cycle 5 after acceptance. inc is high for N cycles until inner_openable goes 1. inner_door_sw pulses once. busy low 5 cycles later.
- Inner->outer traversal starting at outer level: inc high until inner_openable=1, then inner_door_sw pulse. dec high until outer_openable=1, then outer_door_sw pulse. Never inc&dec together.
- outer_req and inner_req rise in the same cycle: to_inner=1. inner_req during busy is ignored; after return to IDLE a still-held inner_req is accepted.
- Openable flag stuck 0 in LEVEL_DEP: after 64 cycles state_code=7, fault=1, all pulses 0. Reset clears fault.
- Reset asserted in WAIT_ARR at arr_cnt=3: no door pulse is ever issued. Outputs return to 0 on the next edge.
